parking_gate_scheduler: RTL and testbench
=========================================

PARKING_GATE_SCHEDULER -- requirements
Module: parking_gate_scheduler

Interface
REQ-001 Parameter OPEN_CYCLES, default 8: number of cycles a barrier stays open after an admitted car, legal range 1..255.
REQ-002 Parameter MAX_CAP_PARKING, default 700: total lot capacity used by the entry check.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 start  input  1  asynchronous, active-low reset; low clears all state immediately, high enables operation.
REQ-005 gate_req  input  4  level request per gate; gates 0,1 are entry gates, gates 2,3 are exit gates.
REQ-006 gate_is_uni  input  4  per-gate flag: requesting car is a university car.
REQ-007 uni_car_parked, parked_care  input  16 each  current occupancy counts from the parking datapath.
REQ-008 uni_is_vacated_space, is_vacated_space  input  1 each  vacancy flags from the parking datapath.
REQ-009 car_entered, is_uni_car_entered, car_exited, is_uni_car_exited  output  1 each  registered command strobes to the parking datapath.
REQ-010 gate_grant  output  4  one-hot index of the gate currently being served.
REQ-011 gate_open  output  4  barrier-open drive, at most one bit high.
REQ-012 gate_reject  output  4  one-cycle refusal pulse to the requesting gate.

Function
REQ-013 The FSM SHALL have the states IDLE, DECIDE, OPEN and HOLD; all outputs SHALL be registered.
REQ-014 IDLE: if any gate_req bit is high at edge N, the FSM SHALL select one gate round-robin (search starts at the pointer), latch its index and gate_is_uni bit, drive gate_grant one-hot and enter DECIDE at N+1.
REQ-015 After each selection the round-robin pointer SHALL become (index+1) mod 4.
REQ-016 DECIDE (one cycle): admission SHALL use only the latched values plus the current datapath inputs; a gate_req drop in this cycle SHALL NOT cancel the decision.
REQ-017 Entry admission conditions: uni car: uni_is_vacated_space=1 and uni_car_parked+parked_care < MAX_CAP_PARKING. Other car: is_vacated_space=1 and the same total check.
REQ-018 Total occupancy SHALL be computed 17 bits wide so that it cannot wrap.
REQ-019 Exit admission conditions: uni car: uni_car_parked != 0. Other car: parked_care != 0.
REQ-020 Admitted at edge N+1: at N+2 the matching strobe pair (car_entered/car_exited plus its is_uni_* qualifier) SHALL be high for exactly one cycle, gate_open[idx] SHALL rise, and the FSM SHALL enter OPEN.
REQ-021 Refused: gate_reject[idx] SHALL pulse high at N+2, no strobe SHALL fire, and the FSM SHALL enter HOLD.
REQ-022 OPEN: gate_open[idx] SHALL stay high for exactly OPEN_CYCLES cycles, regardless of gate_req, after which the FSM SHALL enter HOLD with gate_open low.
REQ-023 HOLD: gate_grant SHALL remain asserted until gate_req[idx] is sampled low, then gate_grant SHALL clear and the FSM SHALL enter IDLE; this prevents one request from producing a double count.
REQ-024 Requests from other gates during DECIDE, OPEN or HOLD SHALL be held off and SHALL NOT be lost.
REQ-025 At most one strobe SHALL be high in any cycle, and never more than one per grant.

Reset
REQ-026 While start=0: state=IDLE, pointer=0, and every output =0, including a barrier in mid-open.
REQ-027 Release of start SHALL take effect on the first clk edge at which start is sampled high; a request that is already held is then served normally.

Structure
REQ-028 Shared package parking_pkg SHALL hold the FSM state enum, the gate index constants (ENTRY0=0, ENTRY1=1, EXIT0=2, EXIT1=3), and the OPEN_CYCLES and MAX_CAP_PARKING defaults.
REQ-029 The round-robin selection SHALL be a sub-module rr_arbiter4 (request[3:0], pointer[1:0] -> one-hot grant, index, valid).

Verification
REQ-030 Admitted entry: gate_req=0001, gate_is_uni=0001, uni_is_vacated_space=1, counts 10/5 -> gate_grant=0001 at N+1; car_entered=is_uni_car_entered=1 for one cycle at N+2; gate_open[0] high for 8 cycles.
REQ-031 Capacity limit: uni_car_parked=500, parked_care=200, is_vacated_space=1, gate_req=0010 -> gate_reject=0010 at N+2, no strobe.
REQ-032 Empty exit: gate_req=0100, gate_is_uni=0000, parked_care=0 -> gate_reject[2] pulse, car_exited stays 0.
REQ-033 Fairness: gate_req=1111 held, each request dropped in HOLD and reasserted -> grants in the order 0,1,2,3,0.
REQ-034 Held request: gate_req[1] held high for 30 cycles -> exactly one car_entered strobe.
REQ-035 Reset in OPEN: start=0 at open cycle 3 -> gate_open=0 and gate_grant=0 immediately; after release, gate_req=0 -> FSM stays in IDLE.

Source files
------------

// File: rtl/parking_gate_scheduler_pkg.sv
// rtl/parking_gate_scheduler_pkg.sv - shared types and constants for the parking gate scheduler
// Ports: none (package parking_pkg: FSM state enum, gate index constants, parameter defaults).
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_OPEN   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Gate numbering: two entry barriers followed by two exit barriers.
  localparam int ENTRY0 = 0;
  localparam int ENTRY1 = 1;
  localparam int EXIT0  = 2;
  localparam int EXIT1  = 3;

  localparam int DEF_OPEN_CYCLES     = 8;
  localparam int DEF_MAX_CAP_PARKING = 700;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// rtl/parking_gate_scheduler_if.sv - gate-side request/grant bundle for the parking gate scheduler
// Signals: gate_req/gate_is_uni (gates -> scheduler), gate_grant/gate_open/gate_reject
// (scheduler -> gates). master = gate side, slave = scheduler side.
interface parking_gate_scheduler_if;
  logic [3:0] gate_req;
  logic [3:0] gate_is_uni;
  logic [3:0] gate_grant;
  logic [3:0] gate_open;
  logic [3:0] gate_reject;

  modport master (
    output gate_req, gate_is_uni,
    input  gate_grant, gate_open, gate_reject
  );

  modport slave (
    input  gate_req, gate_is_uni,
    output gate_grant, gate_open, gate_reject
  );
endinterface

// File: rtl/parking_gate_scheduler_arb.sv
// rtl/parking_gate_scheduler_arb.sv - 4-way round-robin selector for gate requests
// Ports: request[3:0] in, pointer[1:0] in (first gate to consider),
//        grant[3:0] one-hot out, index[1:0] out, valid out (any request present).
module rr_arbiter4 (
  input  logic [3:0] request,
  input  logic [1:0] pointer,
  output logic [3:0] grant,
  output logic [1:0] index,
  output logic       valid
);

  logic [1:0] cand;

  // Scan from the farthest offset down to the pointer so the nearest
  // requester at or after the pointer is the last (winning) assignment.
  always_comb begin
    grant = 4'b0000;
    index = 2'd0;
    valid = 1'b0;
    cand  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = pointer + 2'(i);
      if (request[cand]) begin
        grant = 4'b0001 << cand;
        index = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// rtl/parking_gate_scheduler.sv - serialises four barrier gates through one admission FSM
// Ports: clk, start (async active-low reset), gate (request/grant bundle, slave side),
//        uni_car_parked/parked_care/uni_is_vacated_space/is_vacated_space (datapath status in),
//        car_entered/is_uni_car_entered/car_exited/is_uni_car_exited (registered strobes out).
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES     = DEF_OPEN_CYCLES,
  parameter int MAX_CAP_PARKING = DEF_MAX_CAP_PARKING
) (
  input  logic                      clk,
  input  logic                      start,
  parking_gate_scheduler_if.slave   gate,
  input  logic [15:0]               uni_car_parked,
  input  logic [15:0]               parked_care,
  input  logic                      uni_is_vacated_space,
  input  logic                      is_vacated_space,
  output logic                      car_entered,
  output logic                      is_uni_car_entered,
  output logic                      car_exited,
  output logic                      is_uni_car_exited
);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic       uni_q, uni_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] open_q, open_d;
  logic [3:0] reject_q, reject_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ce_q, ce_d, uce_q, uce_d, cx_q, cx_d, ucx_q, ucx_d;

  logic [3:0]  arb_grant;
  logic [1:0]  arb_idx;
  logic        arb_valid;
  logic [16:0] total;
  logic        cap_ok;
  logic        is_exit;
  logic        admit;

  rr_arbiter4 u_arb (
    .request (gate.gate_req),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .index   (arb_idx),
    .valid   (arb_valid)
  );

  // 17-bit sum so two full 16-bit counts can never wrap below the cap.
  assign total  = {1'b0, uni_car_parked} + {1'b0, parked_care};
  assign cap_ok = total < 17'(MAX_CAP_PARKING);

  always_comb begin
    is_exit = 1'b0;
    admit   = 1'b0;
    case (idx_q)
      2'(ENTRY0), 2'(ENTRY1): admit = cap_ok && (uni_q ? uni_is_vacated_space : is_vacated_space);
      2'(EXIT0), 2'(EXIT1): begin
        is_exit = 1'b1;
        admit   = uni_q ? (uni_car_parked != 16'd0) : (parked_care != 16'd0);
      end
      default: admit = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    uni_d    = uni_q;
    grant_d  = grant_q;
    open_d   = open_q;
    cnt_d    = cnt_q;
    reject_d = 4'b0000;
    ce_d     = 1'b0;
    uce_d    = 1'b0;
    cx_d     = 1'b0;
    ucx_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d   = arb_idx;
          uni_d   = gate.gate_is_uni[arb_idx];
          grant_d = arb_grant;
          ptr_d   = arb_idx + 2'd1;
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        // Decision uses only latched gate data; gate_req is not looked at here.
        if (admit) begin
          open_d  = grant_q;
          cnt_d   = 8'(OPEN_CYCLES - 1);
          state_d = ST_OPEN;
          if (is_exit) begin
            cx_d  = 1'b1;
            ucx_d = uni_q;
          end else begin
            ce_d  = 1'b1;
            uce_d = uni_q;
          end
        end else begin
          reject_d = grant_q;
          state_d  = ST_HOLD;
        end
      end
      ST_OPEN: begin
        if (cnt_q == 8'd0) begin
          open_d  = 4'b0000;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        // Wait for the served car to release its request so it cannot be counted twice.
        if (!gate.gate_req[idx_q]) begin
          grant_d = 4'b0000;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      idx_q    <= 2'd0;
      uni_q    <= 1'b0;
      grant_q  <= 4'b0000;
      open_q   <= 4'b0000;
      reject_q <= 4'b0000;
      cnt_q    <= 8'd0;
      ce_q     <= 1'b0;
      uce_q    <= 1'b0;
      cx_q     <= 1'b0;
      ucx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      uni_q    <= uni_d;
      grant_q  <= grant_d;
      open_q   <= open_d;
      reject_q <= reject_d;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
      uce_q    <= uce_d;
      cx_q     <= cx_d;
      ucx_q    <= ucx_d;
    end
  end

  assign gate.gate_grant  = grant_q;
  assign gate.gate_open   = open_q;
  assign gate.gate_reject = reject_q;
  assign car_entered        = ce_q;
  assign is_uni_car_entered = uce_q;
  assign car_exited         = cx_q;
  assign is_uni_car_exited  = ucx_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb/tb_parking_gate_scheduler.sv - directed vector bench for parking_gate_scheduler
module tb_parking_gate_scheduler;
  import parking_pkg::*;

  localparam int OC = 8;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic [15:0] uni_car_parked = '0;
  logic [15:0] parked_care = '0;
  logic        uni_is_vacated_space = 1'b0;
  logic        is_vacated_space = 1'b0;
  logic        car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;

  int tests = 0;
  int fails = 0;

  parking_gate_scheduler_if gif ();

  parking_gate_scheduler #(.OPEN_CYCLES(OC), .MAX_CAP_PARKING(700)) dut (
    .clk                  (clk),
    .start                (start),
    .gate                 (gif),
    .uni_car_parked       (uni_car_parked),
    .parked_care          (parked_care),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [3:0]  uni;
    logic        uvac;
    logic        vac;
    logic [15:0] ucnt;
    logic [15:0] cnt;
    logic [3:0]  grant;
    logic [3:0]  strb;   // {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}
    logic [3:0]  rej;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [3:0] strobes();
    return {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    #3;
    start = 1'b1;
    tick();
  endtask

  initial begin
    int          strobe_cnt;
    int          open_cnt;
    logic [3:0]  exp_open;
    int          order[5];

    //          name       req      uni      uv  v   ucnt    cnt     grant    strb     rej
    vecs[0] = '{"uni_entry",  4'b0001, 4'b0001, 1, 0, 16'd10,  16'd5,   4'b0001, 4'b1100, 4'b0000};
    vecs[1] = '{"cap_full",   4'b0010, 4'b0000, 0, 1, 16'd500, 16'd200, 4'b0010, 4'b0000, 4'b0010};
    vecs[2] = '{"cap_699",    4'b0010, 4'b0000, 0, 1, 16'd499, 16'd200, 4'b0010, 4'b1000, 4'b0000};
    vecs[3] = '{"empty_exit", 4'b0100, 4'b0000, 1, 1, 16'd5,   16'd0,   4'b0100, 4'b0000, 4'b0100};
    vecs[4] = '{"uni_exit",   4'b1000, 4'b1000, 0, 0, 16'd3,   16'd0,   4'b1000, 4'b0011, 4'b0000};
    vecs[5] = '{"uni_novac",  4'b0001, 4'b0001, 0, 1, 16'd1,   16'd1,   4'b0001, 4'b0000, 4'b0001};
    vecs[6] = '{"wrap_sum",   4'b0001, 4'b0000, 1, 1, 16'hFFFF, 16'hFFFF, 4'b0001, 4'b0000, 4'b0001};

    gif.gate_req    = 4'b0000;
    gif.gate_is_uni = 4'b0000;
    #12;
    chk("rst_grant", 32'(gif.gate_grant), 32'h0);
    chk("rst_open", 32'(gif.gate_open), 32'h0);
    chk("rst_reject", 32'(gif.gate_reject), 32'h0);
    chk("rst_strobes", 32'(strobes()), 32'h0);
    start = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      uni_car_parked       = vecs[v].ucnt;
      parked_care          = vecs[v].cnt;
      uni_is_vacated_space = vecs[v].uvac;
      is_vacated_space     = vecs[v].vac;
      gif.gate_is_uni      = vecs[v].uni;
      gif.gate_req         = vecs[v].req;
      tick();
      chk({vecs[v].name, "_grant"}, 32'(gif.gate_grant), 32'(vecs[v].grant));
      chk({vecs[v].name, "_early"}, 32'(strobes()), 32'h0);
      gif.gate_req = 4'b0000;  // dropping during DECIDE must not cancel
      tick();
      exp_open = (vecs[v].strb != 4'b0000) ? vecs[v].grant : 4'b0000;
      chk({vecs[v].name, "_strb"}, 32'(strobes()), 32'(vecs[v].strb));
      chk({vecs[v].name, "_rej"}, 32'(gif.gate_reject), 32'(vecs[v].rej));
      chk({vecs[v].name, "_open"}, 32'(gif.gate_open), 32'(exp_open));
      tick();
      chk({vecs[v].name, "_pulse"}, 32'({strobes(), gif.gate_reject}), 32'h0);
      repeat (OC + 1) tick();
      chk({vecs[v].name, "_idle"}, 32'({gif.gate_grant, gif.gate_open}), 32'h0);
    end

    // Held request: one strobe, barrier open exactly OC cycles
    uni_car_parked = 16'd10; parked_care = 16'd5;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    gif.gate_is_uni = 4'b0000;
    gif.gate_req = 4'b0010;
    strobe_cnt = 0; open_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (car_entered) strobe_cnt++;
      if (gif.gate_open[1]) open_cnt++;
    end
    chk("held_strobes", 32'(strobe_cnt), 32'd1);
    chk("held_open_cycles", 32'(open_cnt), 32'(OC));
    chk("held_grant", 32'(gif.gate_grant), 32'b0010);
    gif.gate_req = 4'b0000;
    tick(); tick();
    chk("held_release", 32'(gif.gate_grant), 32'h0);

    // Fairness from a fresh pointer: 0,1,2,3,0
    do_reset();
    order = '{0, 1, 2, 3, 0};
    gif.gate_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), 32'(gif.gate_grant), 32'(4'b0001 << order[k]));
      tick();
      chk($sformatf("rr_strobe%0d", k), 32'(car_entered ^ car_exited), 32'd1);
      repeat (OC) tick();
      gif.gate_req[order[k]] = 1'b0;
      tick();
      gif.gate_req[order[k]] = 1'b1;
    end
    gif.gate_req = 4'b0000;
    repeat (OC + 4) tick();

    // Reset during OPEN clears barrier and grant at once
    gif.gate_req = 4'b0001;
    tick();
    tick();
    gif.gate_req = 4'b0000;
    tick(); tick();
    chk("mid_open_before", 32'(gif.gate_open), 32'b0001);
    start = 1'b0;
    #1;
    chk("mid_open_rst", 32'({gif.gate_open, gif.gate_grant}), 32'h0);
    repeat (2) tick();
    start = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 32'({gif.gate_grant, gif.gate_open, strobes()}), 32'h0);

    // Request held through reset is served after release
    start = 1'b0;
    gif.gate_req = 4'b0100;
    repeat (2) tick();
    chk("in_rst_grant", 32'(gif.gate_grant), 32'h0);
    start = 1'b1;
    tick();
    chk("release_grant", 32'(gif.gate_grant), 32'b0100);
    tick();
    chk("release_exit", 32'(car_exited), 32'd1);
    gif.gate_req = 4'b0000;
    repeat (OC + 2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
